// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with a run/stop FSM, shadowed ratio updates
// that take effect on period boundaries, and glitch-free registered o_clk.
module clk_div_ctrl #(
  parameter int W       = 8,
  parameter int DEF_DIV = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         o_clk,
  output logic         period_done,
  output logic         cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam logic [W-1:0] DEF_DIV_W = W'(DEF_DIV);
  localparam logic [W-1:0] ZERO_W    = {W{1'b0}};
  localparam logic [W-1:0] ONE_W     = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] TWO_W     = W'(2);

  // Length of the low phase: ceil(n/2), computed one bit wider to avoid overflow.
  function automatic logic [W-1:0] low_len(input logic [W-1:0] n);
    logic [W:0] t;
    t = {1'b0, n} + {{W{1'b0}}, 1'b1};
    return t[W:1];
  endfunction

  state_t       state_r, state_s;
  logic [W-1:0] cnt_r, cnt_s;
  logic [W-1:0] div_r, div_s;
  logic [W-1:0] shadow_r, shadow_s;
  logic         o_clk_r, o_clk_s;
  logic         period_done_r, period_done_s;
  logic         cfg_err_r, cfg_err_s;
  logic         cfg_ready_r, cfg_ready_s;

  logic         hs_s;
  logic         cfg_bad_s;
  logic         cfg_ok_s;
  logic         boundary_s;
  logic [W-1:0] cnt_adv_s;
  logic         active_nxt_s;

  // Next-state, counter and ratio bookkeeping. The shadow always mirrors the
  // active ratio unless an update is pending, so boundaries can load it blindly.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    div_s      = div_r;
    shadow_s   = shadow_r;
    hs_s       = cfg_valid && cfg_ready_r;
    cfg_bad_s  = (cfg_div < TWO_W);
    cfg_ok_s   = hs_s && !cfg_bad_s;
    boundary_s = (state_r != IDLE) && (cnt_r == (div_r - ONE_W));
    if (boundary_s) begin
      cnt_adv_s = ZERO_W;
    end else begin
      cnt_adv_s = cnt_r + ONE_W;
    end

    case (state_r)
      IDLE: begin
        cnt_s = ZERO_W;
        if (cfg_ok_s) begin
          div_s    = cfg_div;
          shadow_s = cfg_div;
        end else begin
          div_s    = div_r;
        end
        if (en) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        cnt_s = cnt_adv_s;
        if (boundary_s) begin
          // Update on the last cycle of a period applies to the very next one.
          if (cfg_ok_s) begin
            div_s    = cfg_div;
            shadow_s = cfg_div;
          end else begin
            div_s    = div_r;
          end
          if (en) begin
            state_s = RUN;
          end else begin
            state_s = IDLE;
          end
        end else begin
          if (cfg_ok_s) begin
            shadow_s = cfg_div;
          end else begin
            shadow_s = shadow_r;
          end
          if (!en) begin
            state_s = STOP;
          end else if (cfg_ok_s) begin
            state_s = PEND;
          end else begin
            state_s = RUN;
          end
        end
      end
      PEND: begin
        cnt_s = cnt_adv_s;
        if (boundary_s) begin
          div_s = shadow_r;
          if (en) begin
            state_s = PEND;
          end else begin
            state_s = IDLE;
          end
        end else if (cnt_r == ZERO_W) begin
          // cnt==0 in PEND only follows the boundary: new ratio is now live.
          if (en) begin
            state_s = RUN;
          end else begin
            state_s = STOP;
          end
        end else begin
          if (en) begin
            state_s = PEND;
          end else begin
            state_s = STOP;
          end
        end
      end
      STOP: begin
        cnt_s = cnt_adv_s;
        if (boundary_s) begin
          div_s   = shadow_r;
          state_s = IDLE;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s  = IDLE;
        cnt_s    = ZERO_W;
        div_s    = div_r;
        shadow_s = div_r;
      end
    endcase
  end

  // Output values for the next cycle, derived from next-state so outputs stay aligned with cnt.
  always_comb begin
    active_nxt_s  = (state_s != IDLE);
    o_clk_s       = active_nxt_s && (cnt_s >= low_len(div_s));
    period_done_s = active_nxt_s && (cnt_s == (div_s - ONE_W));
    cfg_ready_s   = (state_s == IDLE) || (state_s == RUN);
    cfg_err_s     = hs_s && cfg_bad_s;
  end

  // State, counter and ratio registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= ZERO_W;
      div_r    <= DEF_DIV_W;
      shadow_r <= DEF_DIV_W;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      div_r    <= div_s;
      shadow_r <= shadow_s;
    end
  end

  // Registered outputs; reset forces o_clk low immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_clk_r       <= 1'b0;
      period_done_r <= 1'b0;
      cfg_err_r     <= 1'b0;
      cfg_ready_r   <= 1'b1;
    end else begin
      o_clk_r       <= o_clk_s;
      period_done_r <= period_done_s;
      cfg_err_r     <= cfg_err_s;
      cfg_ready_r   <= cfg_ready_s;
    end
  end

  assign o_clk       = o_clk_r;
  assign period_done = period_done_r;
  assign cfg_err     = cfg_err_r;
  assign cfg_ready   = cfg_ready_r;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed testbench for clk_div_ctrl: hand-computed o_clk / period_done /
// cfg_ready sequences for each scenario, sampled on the falling edge.
module tb_clk_div_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_div = 8'd0;
  logic         cfg_ready;
  logic         o_clk;
  logic         period_done;
  logic         cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  clk_div_ctrl #(.W(W), .DEF_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .o_clk(o_clk), .period_done(period_done), .cfg_err(cfg_err)
  );

  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #4;
    n_tests++;
    if ({o_clk, period_done, cfg_ready, cfg_err} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_async: got %b want 0010", {o_clk, period_done, cfg_ready, cfg_err});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({o_clk, period_done, cfg_ready, cfg_err} !== 4'b0010) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got %b want 0010", i, {o_clk, period_done, cfg_ready, cfg_err});
      end
    end
  endtask

  task automatic test_div2();
    logic [2:0] exp_q [$];
    do_reset();
    en = 1'b1;
    tick();
    exp_q = '{3'b001, 3'b111, 3'b001, 3'b111, 3'b001, 3'b111};
    foreach (exp_q[i]) begin
      n_tests++;
      if ({o_clk, period_done, cfg_ready} !== exp_q[i]) begin
        n_fail++;
        $display("FAIL div2[%0d]: o/done/ready got %b want %b", i, {o_clk, period_done, cfg_ready}, exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_div5();
    logic [2:0] exp_v;
    do_reset();
    cfg_valid = 1'b1; cfg_div = 8'd5;
    tick();
    cfg_valid = 1'b0;
    n_tests++;
    if ({o_clk, period_done, cfg_ready, cfg_err} !== 4'b0010) begin
      n_fail++;
      $display("FAIL div5_idle_load: got %b want 0010", {o_clk, period_done, cfg_ready, cfg_err});
    end
    en = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      exp_v = {((i % 5) >= 3), ((i % 5) == 4), 1'b1};
      n_tests++;
      if ({o_clk, period_done, cfg_ready} !== exp_v) begin
        n_fail++;
        $display("FAIL div5[%0d]: got %b want %b", i, {o_clk, period_done, cfg_ready}, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_reconfig();
    logic [2:0] exp_q [$];
    do_reset();
    cfg_valid = 1'b1; cfg_div = 8'd4; en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    n_tests++;
    if ({o_clk, period_done, cfg_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL reconf_cnt1: got %b want 001", {o_clk, period_done, cfg_ready});
    end
    cfg_valid = 1'b1; cfg_div = 8'd6;
    tick();
    cfg_valid = 1'b0;
    exp_q = '{3'b100, 3'b110, 3'b000, 3'b001, 3'b001, 3'b101, 3'b101, 3'b111, 3'b001};
    foreach (exp_q[i]) begin
      n_tests++;
      if ({o_clk, period_done, cfg_ready} !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reconf[%0d]: got %b want %b", i, {o_clk, period_done, cfg_ready}, exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_stop();
    logic [2:0] exp_q [$];
    do_reset();
    cfg_valid = 1'b1; cfg_div = 8'd6; en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    repeat (4) tick();
    n_tests++;
    if ({o_clk, period_done, cfg_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL stop_cnt4: got %b want 101", {o_clk, period_done, cfg_ready});
    end
    en = 1'b0;
    tick();
    n_tests++;
    if ({o_clk, period_done, cfg_ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL stop_last: got %b want 110", {o_clk, period_done, cfg_ready});
    end
    en = 1'b1;
    tick();
    exp_q = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b101};
    foreach (exp_q[i]) begin
      n_tests++;
      if ({o_clk, period_done, cfg_ready} !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stop_restart[%0d]: got %b want %b", i, {o_clk, period_done, cfg_ready}, exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_cfg_err();
    logic [2:0] exp_q [$];
    do_reset();
    cfg_valid = 1'b1; cfg_div = 8'd0;
    tick();
    cfg_valid = 1'b0;
    n_tests++;
    if ({cfg_err, cfg_ready, o_clk} !== 3'b110) begin
      n_fail++;
      $display("FAIL err_idle: err/ready/o got %b want 110", {cfg_err, cfg_ready, o_clk});
    end
    cfg_valid = 1'b1; cfg_div = 8'd4; en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    cfg_valid = 1'b1; cfg_div = 8'd1;
    tick();
    cfg_valid = 1'b0;
    n_tests++;
    if ({cfg_err, o_clk, period_done, cfg_ready} !== 4'b1101) begin
      n_fail++;
      $display("FAIL err_run_pulse: got %b want 1101", {cfg_err, o_clk, period_done, cfg_ready});
    end
    tick();
    n_tests++;
    if ({cfg_err, o_clk, period_done, cfg_ready} !== 4'b0111) begin
      n_fail++;
      $display("FAIL err_run_clear: got %b want 0111", {cfg_err, o_clk, period_done, cfg_ready});
    end
    tick();
    exp_q = '{3'b001, 3'b001, 3'b101, 3'b111, 3'b001};
    foreach (exp_q[i]) begin
      n_tests++;
      if ({o_clk, period_done, cfg_ready} !== exp_q[i]) begin
        n_fail++;
        $display("FAIL err_keep4[%0d]: got %b want %b", i, {o_clk, period_done, cfg_ready}, exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_q [$];
    do_reset();
    cfg_valid = 1'b1; cfg_div = 8'd4; en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({o_clk, period_done, cfg_ready} !== 3'b111) begin
      n_fail++;
      $display("FAIL b2b_boundary: got %b want 111", {o_clk, period_done, cfg_ready});
    end
    cfg_valid = 1'b1; cfg_div = 8'd3;
    tick();
    cfg_valid = 1'b0;
    exp_q = '{3'b001, 3'b001, 3'b111, 3'b001, 3'b001, 3'b111};
    foreach (exp_q[i]) begin
      n_tests++;
      if ({o_clk, period_done, cfg_ready} !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got %b want %b", i, {o_clk, period_done, cfg_ready}, exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_stop_pending();
    logic [2:0] exp_q [$];
    do_reset();
    cfg_valid = 1'b1; cfg_div = 8'd4; en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    cfg_valid = 1'b1; cfg_div = 8'd6; en = 1'b0;
    tick();
    cfg_valid = 1'b0;
    exp_q = '{3'b100, 3'b110, 3'b001};
    foreach (exp_q[i]) begin
      n_tests++;
      if ({o_clk, period_done, cfg_ready} !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stoppend[%0d]: got %b want %b", i, {o_clk, period_done, cfg_ready}, exp_q[i]);
      end
      tick();
    end
    en = 1'b1;
    tick();
    exp_q = '{3'b001, 3'b001, 3'b001, 3'b101, 3'b101, 3'b111, 3'b001};
    foreach (exp_q[i]) begin
      n_tests++;
      if ({o_clk, period_done, cfg_ready} !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stoppend_n6[%0d]: got %b want %b", i, {o_clk, period_done, cfg_ready}, exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] exp_q [$];
    do_reset();
    cfg_valid = 1'b1; cfg_div = 8'd4; en = 1'b1;
    tick();
    cfg_div = 8'd6;
    tick();
    cfg_valid = 1'b0;
    tick();
    n_tests++;
    if ({o_clk, period_done, cfg_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL arst_pre: got %b want 100", {o_clk, period_done, cfg_ready});
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_clk, period_done, cfg_ready, cfg_err} !== 4'b0010) begin
      n_fail++;
      $display("FAIL arst_mid: got %b want 0010", {o_clk, period_done, cfg_ready, cfg_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    tick();
    exp_q = '{3'b001, 3'b111, 3'b001, 3'b111};
    foreach (exp_q[i]) begin
      n_tests++;
      if ({o_clk, period_done, cfg_ready} !== exp_q[i]) begin
        n_fail++;
        $display("FAIL arst_def[%0d]: got %b want %b", i, {o_clk, period_done, cfg_ready}, exp_q[i]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_div2();
    test_div5();
    test_reconfig();
    test_stop();
    test_cfg_err();
    test_back_to_back();
    test_stop_pending();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
